alu_share_arb: RTL and testbench
================================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001: Parameter W, default 32, operand/result width; only 32 is supported.
REQ-002: clk  in  1  single clock; all state updates on rising edge.
REQ-003: rst  in  1  reset; synchronous, active-high.
REQ-004: req_valid  in  2  per-requester request valid; bit 0 = core, bit 1 = GEMM accelerator.
REQ-005: req_ready  out  2  per-requester request accept; at most one bit high per cycle.
REQ-006: req_op  in  8  opcodes; [3:0] requester 0, [7:4] requester 1; ALU_CON encoding.
REQ-007: req_a  in  64  A operands; [31:0] requester 0, [63:32] requester 1.
REQ-008: req_b  in  64  B operands; same packing as req_a.
REQ-009: rsp_valid  out  2  per-requester response valid; at most one bit high.
REQ-010: rsp_ready  in  2  per-requester response accept.
REQ-011: rsp_data  out  32  registered ALU result for the requester flagged in rsp_valid.
REQ-012: rsp_err  out  1  registered illegal-opcode flag, qualified by rsp_valid.
REQ-013: alu_a, alu_b  out  32 each  operands to the shared combinational ALU.
REQ-014: alu_con  out  4  ALU operation select.
REQ-015: alu_result  in  32  combinational ALU output, same cycle as alu_a/alu_b/alu_con.

Function
REQ-016: Two states: IDLE (no response held) and RESP (response held in rsp_data/rsp_err).
REQ-017: A request can be accepted in IDLE, or in RESP in the cycle the held response handshakes (rsp_valid & rsp_ready).
REQ-018: When acceptance is possible and at least one req_valid bit is high, exactly one requester is granted; its req_ready bit is high combinationally.
REQ-019: The granted requester's op/a/b drive alu_con/alu_a/alu_b; with no grant these outputs are 0.
REQ-020: A request is accepted when req_valid & req_ready for the same bit; alu_result is captured into rsp_data, the grant index into an owner register, and the state goes to (or stays in) RESP.
REQ-021: Latency: a request accepted in cycle N has rsp_valid[owner] high in cycle N+1.
REQ-022: In RESP, rsp_valid[owner] stays high with rsp_data/rsp_err stable until rsp_ready[owner]; rsp_ready on the other bit is ignored.
REQ-023: RESP with handshake and no new acceptance goes to IDLE; with a new acceptance it stays in RESP and gives one result per cycle.
REQ-024: In RESP without a handshake, req_ready is 0 on both bits.
REQ-025: Round-robin: when both requesters are valid, the one not granted last wins; a sole valid requester always wins.
REQ-026: last_grant updates only on acceptance.
REQ-027: Opcodes 4'b1011-4'b1111 are still issued to the ALU; rsp_data captures alu_result and rsp_err = 1.
REQ-028: For legal opcodes 4'b0000-4'b1010, rsp_err = 0.
REQ-029: A requester whose valid drops before acceptance loses nothing; there is no grant lock across cycles.

Reset
REQ-030: When rst is high at a clock edge, state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_err = 0, owner = 0, last_grant = 1 (requester 0 wins first contention).
REQ-031: Reset mid-operation discards any held response without a handshake.
REQ-032: While rst is high, req_ready = 0 and alu_a/alu_b/alu_con = 0.

Configuration
REQ-033: Macro ALU_ARB_FIXED_PRIO_EN.
REQ-034: Macro defined: requester 1 (accelerator) always wins contention; last_grant is not implemented.
REQ-035: Macro undefined: round-robin per REQ-025/REQ-026.

Verification
REQ-036: Reset, then r0 only, op 0000, a=5, b=7 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data=12, rsp_err=0.
REQ-037: Both valid every cycle, rsp_ready=11, ops 0001 (r0 a=10,b=3) and 0100 (r1 a=1,b=2) -> grants 0,1,0,1; rsp_data 7,1,7,1 alternating; one response per cycle. With ALU_ARB_FIXED_PRIO_EN -> grants 1,1,1,1.
REQ-038: r0 accepted, rsp_ready=00 for 3 cycles with r1 valid -> rsp_valid=01 held, rsp_data stable, req_ready=00; release rsp_ready=01 -> r1 accepted in that same cycle.
REQ-039: r1 op 1111, a=b=0xFFFFFFFF -> rsp_valid=10, rsp_data=0 (ALU default), rsp_err=1.
REQ-040: rst asserted while in RESP with rsp_ready=00 -> next cycle rsp_valid=00, rsp_data=0; first post-reset contention grants r0.

Source files
------------

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter in front of a shared combinational ALU with a registered response slot
// Optional feature: define ALU_ARB_FIXED_PRIO_EN for fixed priority (accelerator wins) instead of round-robin.
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [7:0]     req_op,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [3:0]     alu_con,
    input  logic [W-1:0]   alu_result
);

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_err;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           r_last_grant;
`endif

    logic           w_hs;
    logic           w_can_accept;
    logic           w_grant;
    logic           w_accept;
    logic [3:0]     w_op;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;

    assign w_hs         = (r_state == S_RESP) && rsp_ready[r_owner];
    assign w_can_accept = !rst && ((r_state == S_IDLE) || w_hs);
    assign w_accept     = w_can_accept && (|req_valid);

    // Grant index; only meaningful when w_accept is high.
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant = req_valid[1];
`else
    assign w_grant = (&req_valid) ? ~r_last_grant : req_valid[1];
`endif

    assign w_op = w_grant ? req_op[7:4]      : req_op[3:0];
    assign w_a  = w_grant ? req_a[2*W-1:W]   : req_a[W-1:0];
    assign w_b  = w_grant ? req_b[2*W-1:W]   : req_b[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_RESP;
        end else if (w_hs) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        alu_con   = 4'd0;
        alu_a     = '0;
        alu_b     = '0;
        if (w_accept) begin
            req_ready = {w_grant, ~w_grant};
            alu_con   = w_op;
            alu_a     = w_a;
            alu_b     = w_b;
        end
        if (r_state == S_RESP) begin
            rsp_valid = {r_owner, ~r_owner};
        end
    end

    // Opcodes above 4'b1010 still go to the ALU but are flagged as illegal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_owner      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else if (w_accept) begin
            r_rsp_data   <= alu_result;
            r_rsp_err    <= (w_op > 4'b1010);
            r_owner      <= w_grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= w_grant;
`endif
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with a behavioural shared ALU
module tb_alu_share_arb;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_op = 8'h00;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_con;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    alu_share_arb #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_con(alu_con),
        .alu_result(alu_result)
    );

    always_comb begin
        alu_result = 32'd0;
        case (alu_con)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0101: alu_result = alu_a ^ alu_b;
            4'b1010: alu_result = alu_a;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [1:0] v,
                       input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic [1:0] rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_op    = {op1, op0};
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        rsp_ready = rr;
        @(negedge clk);
    endtask

    task automatic push(input logic owner, input logic err, input logic [31:0] data);
        exp_q.push_back({owner, err, data});
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && (|(rsp_valid & rsp_ready))) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {62'd0, rsp_valid}, {62'd0, e[33], ~e[33]});
                chk("rsp_err",   {63'd0, rsp_err}, {63'd0, e[32]});
                chk("rsp_data",  {32'd0, rsp_data}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        // Reset: outputs and ALU drive must stay quiet even with requests pending.
        cyc(2'b11, 4'h0, 32'd1, 32'd1, 4'h0, 32'd1, 32'd1, 2'b11);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_alu_con",   {60'd0, alu_con}, 64'd0);
        chk("rst_alu_a",     {32'd0, alu_a}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data",  {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);

        // Single add from the core
        cyc(2'b01, 4'h0, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 2'b11);
        chk("add_ready", {62'd0, req_ready}, 64'd1);
        push(1'b0, 1'b0, 32'd12);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);

        // Contention, one result per cycle; reset first so arbitration restarts
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 4'h1, 32'd10, 32'd3, 4'h4, 32'd1, 32'd2, 2'b11);
            g = FIXED ? 1'b1 : i[0];
            chk("rr_grant", {62'd0, req_ready}, {62'd0, g, ~g});
            push(g, 1'b0, g ? 32'd1 : 32'd7);
        end
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);

        // Backpressure hold; rsp_ready on the non-owner bit must be ignored
        cyc(2'b01, 4'h0, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 2'b00);
        chk("bp_accept", {62'd0, req_ready}, 64'd1);
        push(1'b0, 1'b0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b10, 4'h0, 32'd0, 32'd0, 4'h2, 32'hF0, 32'h3C, (i == 1) ? 2'b10 : 2'b00);
            chk("bp_req_ready", {62'd0, req_ready}, 64'd0);
            chk("bp_rsp_valid", {62'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data",  {32'd0, rsp_data}, 64'd3);
        end
        cyc(2'b10, 4'h0, 32'd0, 32'd0, 4'h2, 32'hF0, 32'h3C, 2'b01);
        chk("bp_release_grant", {62'd0, req_ready}, 64'd2);
        push(1'b1, 1'b0, 32'h30);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);

        // Opcode legality boundary: 1010 legal, 1011 and 1111 illegal
        cyc(2'b01, 4'hA, 32'h1234, 32'd9, 4'h0, 32'd0, 32'd0, 2'b11);
        chk("op1010_ready", {62'd0, req_ready}, 64'd1);
        push(1'b0, 1'b0, 32'h1234);
        cyc(2'b10, 4'h0, 32'd0, 32'd0, 4'hB, 32'd5, 32'd6, 2'b11);
        chk("op1011_ready", {62'd0, req_ready}, 64'd2);
        push(1'b1, 1'b1, 32'd0);
        cyc(2'b10, 4'h0, 32'd0, 32'd0, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
        chk("op1111_alu_con", {60'd0, alu_con}, 64'hF);
        push(1'b1, 1'b1, 32'd0);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);

        // Reset while holding a response discards it and restores r0 priority
        cyc(2'b01, 4'h0, 32'd2, 32'd2, 4'h0, 32'd0, 32'd0, 2'b00);
        chk("mid_accept", {62'd0, req_ready}, 64'd1);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b00);
        chk("mid_hold_valid", {62'd0, rsp_valid}, 64'd1);
        chk("mid_hold_data",  {32'd0, rsp_data}, 64'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("mid_rst_ready", {62'd0, req_ready}, 64'd0);
        chk("mid_rst_alu_b", {32'd0, alu_b}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_op = {4'h1, 4'h0};
        req_a  = {32'd9, 32'd2};
        req_b  = {32'd4, 32'd2};
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("post_rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("post_rst_rsp_data",  {32'd0, rsp_data}, 64'd0);
        chk("post_rst_grant", {62'd0, req_ready}, FIXED ? 64'd2 : 64'd1);
        push(FIXED, 1'b0, FIXED ? 32'd5 : 32'd4);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);
        cyc(2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b11);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
